// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, instruction memory and IF/ID register.
// Redirects on branch-unit taken, honours stall/step, freezes on HALT.
module instruction_fetch_stage #(
    parameter int PROC_BITS = 32,
    parameter int PC_BITS = 32,
    parameter int MEM_ADDR_BITS = 8,
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic                     i_stall,
    input  logic                     i_taken,
    input  logic [PC_BITS-1:0]       i_jump_address,
    input  logic                     i_mem_write_enable,
    input  logic [MEM_ADDR_BITS-1:0] i_mem_write_addr,
    input  logic [PROC_BITS-1:0]     i_mem_write_data,
    output logic [PROC_BITS-1:0]     o_instruction,
    output logic [PC_BITS-1:0]       o_pc_next,
    output logic [PC_BITS-1:0]       o_pc,
    output logic                     o_halt
);

    localparam int DEPTH = 2 ** MEM_ADDR_BITS;

    logic [PROC_BITS-1:0] mem [DEPTH];

    logic [PC_BITS-1:0]   pc;
    logic [PC_BITS-1:0]   pc_d;
    logic [PC_BITS-1:0]   pc_inc;
    logic [PROC_BITS-1:0] instr_d;
    logic [PC_BITS-1:0]   pc_next_d;
    logic                 halt_d;
    logic [PROC_BITS-1:0] fetch_word;
    logic                 fetch_is_halt;

    // Program-load port is independent of stage control and reset.
    always_ff @(posedge clk) begin
        if (i_mem_write_enable) begin
            mem[i_mem_write_addr] <= i_mem_write_data;
        end
    end

    assign fetch_word    = mem[pc[MEM_ADDR_BITS-1:0]];
    assign fetch_is_halt = (fetch_word[PROC_BITS-1 -: 6] == HALT_OPCODE);
    assign pc_inc        = pc + PC_BITS'(1);

    always_comb begin
        pc_d      = pc;
        instr_d   = o_instruction;
        pc_next_d = o_pc_next;
        halt_d    = o_halt;
        if (!i_enable) begin
            pc_d = pc;
        end else if (o_halt) begin
            instr_d = '0;
        end else if (i_stall) begin
            pc_d = pc;
        end else if (i_taken) begin
            // Wrong-path word is squashed, so its opcode never halts.
            pc_d      = i_jump_address;
            instr_d   = '0;
            pc_next_d = '0;
        end else begin
            instr_d   = fetch_word;
            pc_next_d = pc_inc;
            if (fetch_is_halt) begin
                halt_d = 1'b1;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= '0;
            o_instruction <= '0;
            o_pc_next     <= '0;
            o_halt        <= 1'b0;
        end else begin
            pc            <= pc_d;
            o_instruction <= instr_d;
            o_pc_next     <= pc_next_d;
            o_halt        <= halt_d;
        end
    end

    assign o_pc = pc;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: per-cycle reference model
// plus directed literal checks.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst;
    logic        i_enable;
    logic        i_stall;
    logic        i_taken;
    logic [31:0] i_jump_address;
    logic        i_mem_write_enable;
    logic [7:0]  i_mem_write_addr;
    logic [31:0] i_mem_write_data;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_next;
    logic [31:0] o_pc;
    logic        o_halt;

    int errors = 0;
    int checks = 0;

    instruction_fetch_stage dut (
        .clk                (clk),
        .rst                (rst),
        .i_enable           (i_enable),
        .i_stall            (i_stall),
        .i_taken            (i_taken),
        .i_jump_address     (i_jump_address),
        .i_mem_write_enable (i_mem_write_enable),
        .i_mem_write_addr   (i_mem_write_addr),
        .i_mem_write_data   (i_mem_write_data),
        .o_instruction      (o_instruction),
        .o_pc_next          (o_pc_next),
        .o_pc               (o_pc),
        .o_halt             (o_halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [31:0] m_mem [256];
    logic [31:0] m_pc = 0;
    logic [31:0] m_ins = 0;
    logic [31:0] m_pcn = 0;
    logic        m_halt = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] w;
        w = m_mem[m_pc[7:0]];
        if (rst) begin
            m_pc = 0;
            m_ins = 0;
            m_pcn = 0;
            m_halt = 0;
        end else if (i_enable) begin
            if (m_halt) begin
                m_ins = 0;
            end else if (!i_stall) begin
                if (i_taken) begin
                    m_pc = i_jump_address;
                    m_ins = 0;
                    m_pcn = 0;
                end else begin
                    m_ins = w;
                    m_pcn = m_pc + 1;
                    if (w[31:26] == 6'h3f) m_halt = 1;
                    else m_pc = m_pc + 1;
                end
            end
        end
        if (i_mem_write_enable) m_mem[i_mem_write_addr] = i_mem_write_data;
        #1;
        chk("m_pc", o_pc, m_pc);
        chk("m_instr", o_instruction, m_ins);
        chk("m_pc_next", o_pc_next, m_pcn);
        chk("m_halt", {31'd0, o_halt}, {31'd0, m_halt});
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] word;
        rst = 1;
        i_enable = 0;
        i_stall = 0;
        i_taken = 0;
        i_jump_address = 0;
        i_mem_write_enable = 0;
        i_mem_write_addr = 0;
        i_mem_write_data = 0;

        for (int i = 0; i < 256; i++) begin
            step();
            case (i)
                0: word = 32'h20010005;
                1: word = 32'h20020007;
                2: word = 32'h00000000;
                3: word = 32'hFC000000;
                8'h13: word = 32'hFC000013;
                default: word = 32'h10000000 | i;
            endcase
            i_mem_write_enable = 1;
            i_mem_write_addr = 8'(i);
            i_mem_write_data = word;
        end
        step();
        i_mem_write_enable = 0;
        i_enable = 1;
        step();
        chk("reset_pc", o_pc, 0);
        chk("reset_instr", o_instruction, 0);
        chk("reset_halt", {31'd0, o_halt}, 0);
        rst = 0;

        // Straight fetch into HALT
        step();
        chk("f0_instr", o_instruction, 32'h20010005);
        chk("f0_pcn", o_pc_next, 1);
        step();
        chk("f1_instr", o_instruction, 32'h20020007);
        chk("f1_pcn", o_pc_next, 2);
        step();
        chk("f2_instr", o_instruction, 0);
        chk("f2_pcn", o_pc_next, 3);
        step();
        chk("f3_instr", o_instruction, 32'hFC000000);
        chk("f3_pcn", o_pc_next, 4);
        chk("f3_halt", {31'd0, o_halt}, 1);
        chk("f3_pc", o_pc, 3);
        i_taken = 1;
        i_jump_address = 32'h10;
        step();
        chk("h_instr", o_instruction, 0);
        chk("h_pc", o_pc, 3);
        chk("h_pcn", o_pc_next, 4);
        step();
        chk("h2_pc", o_pc, 3);

        // Reset while halted
        rst = 1;
        step();
        chk("rh_pc", o_pc, 0);
        chk("rh_halt", {31'd0, o_halt}, 0);
        chk("rh_instr", o_instruction, 0);
        chk("rh_pcn", o_pc_next, 0);
        rst = 0;
        i_taken = 0;
        step();
        chk("refetch0", o_instruction, 32'h20010005);

        // Redirect with one bubble
        i_taken = 1;
        i_jump_address = 4;
        step();
        i_taken = 0;
        step();
        chk("r_pc5", o_pc, 5);
        i_taken = 1;
        i_jump_address = 32'h10;
        step();
        chk("r_pc", o_pc, 32'h10);
        chk("r_bubble", o_instruction, 0);
        chk("r_pcn0", o_pc_next, 0);
        i_taken = 0;
        step();
        chk("r_instr", o_instruction, 32'h10000010);
        chk("r_pcn", o_pc_next, 32'h11);

        // Stall with taken ignored
        i_stall = 1;
        i_taken = 1;
        i_jump_address = 32'h40;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s_pc", o_pc, 32'h11);
            chk("s_instr", o_instruction, 32'h10000010);
            chk("s_pcn", o_pc_next, 32'h11);
        end
        i_stall = 0;
        i_taken = 0;
        step();
        chk("s_resume", o_instruction, 32'h10000011);
        step();
        chk("pre_h_pc", o_pc, 32'h13);

        // Taken on a HALT word must not halt
        i_taken = 1;
        i_jump_address = 32'h20;
        step();
        chk("th_pc", o_pc, 32'h20);
        chk("th_halt", {31'd0, o_halt}, 0);
        i_taken = 0;
        step();
        chk("th_instr", o_instruction, 32'h10000020);

        // Disabled stage with program-load writes
        i_enable = 0;
        i_mem_write_enable = 1;
        i_mem_write_addr = 7;
        i_mem_write_data = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("e_pc", o_pc, 32'h21);
            chk("e_instr", o_instruction, 32'h10000020);
        end
        i_mem_write_enable = 0;
        i_enable = 1;
        i_taken = 1;
        i_jump_address = 7;
        step();
        i_taken = 0;
        step();
        chk("e_fetch7", o_instruction, 32'hDEADBEEF);
        chk("e_pcn", o_pc_next, 8);

        // Same-cycle write returns old word
        i_mem_write_enable = 1;
        i_mem_write_addr = 8;
        i_mem_write_data = 32'hCAFE0001;
        step();
        i_mem_write_enable = 0;
        chk("rw_old", o_instruction, 32'h10000008);

        // PC wrap and address aliasing
        i_taken = 1;
        i_jump_address = 32'hFFFFFFFF;
        step();
        i_taken = 0;
        step();
        chk("w_instr", o_instruction, 32'h100000FF);
        chk("w_pcn", o_pc_next, 0);
        chk("w_pc", o_pc, 0);
        i_taken = 1;
        i_jump_address = 32'h105;
        step();
        i_taken = 0;
        step();
        chk("a_instr", o_instruction, 32'h10000005);
        chk("a_pcn", o_pc_next, 32'h106);

        // Refetch of the rewritten word at 8
        i_taken = 1;
        i_jump_address = 8;
        step();
        i_taken = 0;
        step();
        chk("rw_new", o_instruction, 32'hCAFE0001);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
